// File: rtl/mult_arbiter_if.sv
// Signal bundle between mult_arbiter, its requesters and the shared multiplier.
// The arbiter connects through the slave modport. The requesters and the multiplier connect through the master modport.
interface mult_arbiter_if #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] reqMultiplier;
    logic [NUM_REQ*WIDTH-1:0] reqMultiplicand;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       respValid;
    logic [2*WIDTH-1:0]       respProduct;
    logic                     respError;
    logic                     busy;
    logic                     mulStart;
    logic [WIDTH-1:0]         mulMultiplier;
    logic [WIDTH-1:0]         mulMultiplicand;
    logic [2*WIDTH-1:0]       mulProduct;
    logic                     mulDone;

    modport master (
        output req, reqMultiplier, reqMultiplicand, mulProduct, mulDone,
        input  gnt, respValid, respProduct, respError, busy,
               mulStart, mulMultiplier, mulMultiplicand
    );

    modport slave (
        input  req, reqMultiplier, reqMultiplicand, mulProduct, mulDone,
        output gnt, respValid, respProduct, respError, busy,
               mulStart, mulMultiplier, mulMultiplicand
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one sequential multiplier among NUM_REQ requesters,
// with a watchdog that answers with an error if the multiplier never reports done.
module mult_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    mult_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int SUM_W = PTR_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [2*WIDTH-1:0] resp_product_q, resp_product_d;
    logic               resp_error_q, resp_error_d;
    logic               busy_q, busy_d;
    logic               mul_start_q, mul_start_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;

    logic [SUM_W-1:0]   rr_sum;
    logic [PTR_W-1:0]   rr_cand;
    logic [PTR_W-1:0]   sel_idx;
    logic               sel_found;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    // The search starts at rr_ptr_q and wraps. The single subtract is enough because rr_ptr_q + k < 2*NUM_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        rr_sum    = '0;
        rr_cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (rr_sum >= SUM_W'(NUM_REQ)) begin
                rr_sum = rr_sum - SUM_W'(NUM_REQ);
            end
            rr_cand = rr_sum[PTR_W-1:0];
            if (!sel_found && bus.req[rr_cand]) begin
                sel_found = 1'b1;
                sel_idx   = rr_cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == PTR_W'(i)) begin
                sel_a = bus.reqMultiplier[i*WIDTH +: WIDTH];
                sel_b = bus.reqMultiplicand[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        wait_cnt_d     = wait_cnt_q;
        gnt_d          = gnt_q;
        resp_valid_d   = '0;
        resp_product_d = resp_product_q;
        resp_error_d   = resp_error_q;
        busy_d         = busy_q;
        mul_start_d    = 1'b0;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    gnt_d       = NUM_REQ'(1) << sel_idx;
                    mul_a_d     = sel_a;
                    mul_b_d     = sel_b;
                    rr_ptr_d    = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
                    mul_start_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            // A done seen here belongs to an earlier operation, so it is ignored.
            ISSUE: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (bus.mulDone) begin
                    resp_product_d = bus.mulProduct;
                    resp_error_d   = 1'b0;
                    resp_valid_d   = gnt_q;
                    state_d        = RESP;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    resp_product_d = '0;
                    resp_error_d   = 1'b1;
                    resp_valid_d   = gnt_q;
                    state_d        = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                gnt_d          = '0;
                resp_product_d = '0;
                resp_error_d   = 1'b0;
                busy_d         = 1'b0;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            wait_cnt_q     <= '0;
            gnt_q          <= '0;
            resp_valid_q   <= '0;
            resp_product_q <= '0;
            resp_error_q   <= 1'b0;
            busy_q         <= 1'b0;
            mul_start_q    <= 1'b0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            wait_cnt_q     <= wait_cnt_d;
            gnt_q          <= gnt_d;
            resp_valid_q   <= resp_valid_d;
            resp_product_q <= resp_product_d;
            resp_error_q   <= resp_error_d;
            busy_q         <= busy_d;
            mul_start_q    <= mul_start_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
        end
    end

    assign bus.gnt             = gnt_q;
    assign bus.respValid       = resp_valid_q;
    assign bus.respProduct     = resp_product_q;
    assign bus.respError       = resp_error_q;
    assign bus.busy            = busy_q;
    assign bus.mulStart        = mul_start_q;
    assign bus.mulMultiplier   = mul_a_q;
    assign bus.mulMultiplicand = mul_b_q;
endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one sequential shift-add multiplier (start / product / productDone interface) among NUM_REQ requesters. It grants one requester, latches that requester's operands, and pulses the multiplier start. It then waits for done, routes the product back with a one-cycle response pulse, and recovers from a hung multiplier via a watchdog timeout.

Parameters:
WIDTH, 4, operand width; product is 2*WIDTH
NUM_REQ, 4, number of requesters (>=2)
TIMEOUT, 64, max WAIT cycles before error response (>=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  NUM_REQ  per-requester request level
reqMultiplier  input  NUM_REQ*WIDTH  operand A; slice i = bits [i*WIDTH +: WIDTH]
reqMultiplicand  input  NUM_REQ*WIDTH  operand B; slices as reqMultiplier
gnt  output  NUM_REQ  one-hot grant; zero when idle
respValid  output  NUM_REQ  one-cycle completion pulse to the granted requester
respProduct  output  2*WIDTH  result; valid while any respValid bit is high
respError  output  1  high with respValid when the operation timed out
busy  output  1  high in any state other than IDLE
mulStart  output  1  start pulse to the shared multiplier
mulMultiplier  output  WIDTH  latched operand A to the multiplier
mulMultiplicand  output  WIDTH  latched operand B to the multiplier
mulProduct  input  2*WIDTH  multiplier product
mulDone  input  1  multiplier productDone

Behaviour:
- All outputs are registered.
- Reset, async: state=IDLE, rrPtr=0, waitCnt=0, all outputs 0. Reset during any state aborts the operation with no response.
- The multiplier shares rst.

States:
- IDLE:
  - If req != 0, select the first set bit searching from rrPtr upward, wrapping modulo NUM_REQ.
  - Latch that slice of the operands into mulMultiplier / mulMultiplicand, set gnt one-hot.
  - Set rrPtr = (grant+1) mod NUM_REQ, then go to ISSUE.
  - req is sampled only in IDLE.
- ISSUE: mulStart=1 for exactly this cycle. mulDone is ignored here (stale). Go to WAIT with waitCnt=0.
- WAIT:
  - If mulDone=1: respProduct=mulProduct, respError=0, go to RESP.
  - Else if waitCnt==TIMEOUT-1: respProduct=0, respError=1, go to RESP.
  - Else waitCnt++.
- RESP:
  - respValid[grant]=1 for this one cycle.
  - respProduct / respError are held through this cycle and cleared on return to IDLE.
  - gnt=0 on exit, then go to IDLE.

Signal rules:
- gnt is held constant from ISSUE through RESP.
- Operands are latched, so requester inputs may change after the grant.
- busy=1 in ISSUE, WAIT and RESP.

Latency:
- The multiplier raises mulDone L cycles after the mulStart cycle.
- req seen in IDLE at cycle t → mulStart at t+1 → mulDone at t+1+L → respValid at t+L+2.
- Back-to-back throughput is one operation per L+3 cycles.

Requester protocol:
- Hold req until respValid; drop req the cycle after respValid if there is no further work.
- A req still high in the next IDLE is treated as a new request, arbitrated fairly.
- A req dropped after grant does not cancel the operation; the response is still issued.

Simultaneous events: a new req arriving during ISSUE/WAIT/RESP waits for IDLE. Requests are never lost while held.

Arithmetic: no width conversion; the 2*WIDTH product is passed through unchanged.

Test Plan:
- Bench multiplier model: product = A*B, mulDone asserted L=5 cycles after start; WIDTH=4, NUM_REQ=4.
- Reset: assert rst mid-cycle → all outputs 0 immediately (async); after release, busy=0, gnt=0.
- Single request: req=0010, A=3, B=5 → gnt=0010, mulStart high 1 cycle with mul operands 3/5, respValid=0010 exactly 7 cycles after req sampled, respProduct=15, respError=0.
- Full contention: req=1111 from reset, held until each requester's response, operands (15,15),(2,3),(7,1),(0,9) → grants in order 0,1,2,3; products 225, 6, 7, 0; each respValid a single-cycle pulse.
- Fairness: after a grant to 1, req=0101 pending → requester 2 granted next, then 0.
- Timeout: TIMEOUT=8, model never asserts done → respValid pulses after 8 WAIT cycles with respError=1, respProduct=0; the next request (A=4, B=4) completes normally with 16.
- Stale done / reset mid-op: mulDone high during ISSUE → ignored, result taken at the true done. rst asserted during WAIT → no respValid, rrPtr=0; a re-issued req=1000 is granted to requester 3.
